// File: rtl/digital_tube_scan_if.sv
// Bus bundle between the tube register window of the I/O bridge and
// digital_tube_scan: data/config write ports in, digit select and segments out.
interface digital_tube_scan_if #(
  parameter int DIGITS = 8
);
  logic                  wr_en;
  logic [DIGITS/2-1:0]   wr_be;
  logic [4*DIGITS-1:0]   wr_data;
  logic                  cfg_we;
  logic [DIGITS-1:0]     cfg_dp;
  logic [DIGITS-1:0]     cfg_blink;
  logic                  cfg_lzs;
  logic [3:0]            cfg_bright;
  logic [DIGITS-1:0]     sel;
  logic [7:0]            seg;

  modport master (
    output wr_en, wr_be, wr_data, cfg_we, cfg_dp, cfg_blink, cfg_lzs, cfg_bright,
    input  sel, seg
  );

  modport slave (
    input  wr_en, wr_be, wr_data, cfg_we, cfg_dp, cfg_blink, cfg_lzs, cfg_bright,
    output sel, seg
  );
endinterface

// File: rtl/digital_tube_scan.sv
// Multiplexed seven-segment driver: scans DIGITS hex nibbles one slot at a time,
// with byte-lane writes, per-digit dp, leading-zero suppression and 16-level
// in-slot PWM brightness. Per-digit blinking is built only when TUBE_BLINK_EN
// is defined; otherwise cfg_blink is ignored and digits never blink.
module digital_tube_scan #(
  parameter int DIGITS       = 8,
  parameter int SCAN_PERIOD  = 25000,
  parameter int BLINK_FRAMES = 64
) (
  input  logic                clk,
  input  logic                rstn,
  digital_tube_scan_if.slave  bus
);
  localparam int             CW        = $clog2(SCAN_PERIOD);
  localparam int             IW        = $clog2(DIGITS);
  localparam logic [CW-1:0]  CNT_LAST  = CW'(SCAN_PERIOD - 1);
  localparam logic [IW-1:0]  IDX_LAST  = IW'(DIGITS - 1);
  localparam logic [35:0]    ON_RESET  = 36'(SCAN_PERIOD);
  localparam logic [35:0]    PERIOD_36 = 36'(SCAN_PERIOD);

  // Active-low hex glyph for segments A..G (bit 6 = A, bit 0 = G).
  function automatic logic [6:0] hex_glyph(input logic [3:0] nib);
    logic [6:0] g;
    case (nib)
      4'h0:    g = 7'h01;
      4'h1:    g = 7'h4F;
      4'h2:    g = 7'h12;
      4'h3:    g = 7'h06;
      4'h4:    g = 7'h4C;
      4'h5:    g = 7'h24;
      4'h6:    g = 7'h20;
      4'h7:    g = 7'h0F;
      4'h8:    g = 7'h00;
      4'h9:    g = 7'h04;
      4'hA:    g = 7'h08;
      4'hB:    g = 7'h60;
      4'hC:    g = 7'h31;
      4'hD:    g = 7'h42;
      4'hE:    g = 7'h30;
      4'hF:    g = 7'h38;
      default: g = 7'h7F;
    endcase
    return g;
  endfunction

  logic [CW-1:0]         cnt_q, cnt_d;
  logic [IW-1:0]         idx_q, idx_d;
  logic [4*DIGITS-1:0]   data_q, data_d;
  logic [DIGITS-1:0]     dp_q, dp_d;
  logic                  lzs_q, lzs_d;
  logic [35:0]           on_time_q, on_time_d;
  logic [DIGITS-1:0]     sel_q, sel_d;
  logic [7:0]            seg_q, seg_d;
  logic                  blink_blank_s;
  logic                  upper_zero_s;
  logic                  blank_s;
  logic [3:0]            nib_s;

`ifdef TUBE_BLINK_EN
  localparam int            FW         = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
  localparam logic [FW-1:0] FRAME_LAST = FW'(BLINK_FRAMES - 1);

  logic [FW-1:0]         frame_q, frame_d;
  logic                  blink_ph_q, blink_ph_d;
  logic [DIGITS-1:0]     blink_q, blink_d;
  logic                  frame_wrap_s;

  // Blink state: frame counter advances once per full scan, phase toggles on its wrap.
  always_comb begin
    frame_wrap_s = (cnt_q == CNT_LAST) && (idx_q == IDX_LAST);
    frame_d      = frame_q;
    blink_ph_d   = blink_ph_q;
    if (frame_wrap_s) begin
      if (frame_q == FRAME_LAST) begin
        frame_d    = '0;
        blink_ph_d = ~blink_ph_q;
      end else begin
        frame_d    = frame_q + FW'(1);
      end
    end else begin
      frame_d = frame_q;
    end
    if (bus.cfg_we) begin
      blink_d = bus.cfg_blink;
    end else begin
      blink_d = blink_q;
    end
    blink_blank_s = blink_ph_q & blink_q[idx_q];
  end

  // Blink registers, cleared by reset only; config writes leave the counters running.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      frame_q    <= '0;
      blink_ph_q <= 1'b0;
      blink_q    <= '0;
    end else begin
      frame_q    <= frame_d;
      blink_ph_q <= blink_ph_d;
      blink_q    <= blink_d;
    end
  end
`else
  // Without blink support no digit is ever blanked by blinking.
  always_comb begin
    blink_blank_s = 1'b0;
  end
`endif

  // Scan position: cnt walks the slot, idx steps to the next digit on cnt wrap.
  always_comb begin
    cnt_d = cnt_q;
    idx_d = idx_q;
    if (cnt_q == CNT_LAST) begin
      cnt_d = '0;
      if (idx_q == IDX_LAST) begin
        idx_d = '0;
      end else begin
        idx_d = idx_q + IW'(1);
      end
    end else begin
      cnt_d = cnt_q + CW'(1);
    end
  end

  // Data and config next state; byte lanes not enabled keep their old value.
  always_comb begin
    data_d = data_q;
    for (int k = 0; k < DIGITS/2; k++) begin
      if (bus.wr_en && bus.wr_be[k]) begin
        data_d[8*k +: 8] = bus.wr_data[8*k +: 8];
      end else begin
        data_d[8*k +: 8] = data_q[8*k +: 8];
      end
    end
    if (bus.cfg_we) begin
      dp_d      = bus.cfg_dp;
      lzs_d     = bus.cfg_lzs;
      // Full 36-bit product before the shift so large periods do not truncate.
      on_time_d = ((36'(bus.cfg_bright) + 36'd1) * PERIOD_36) >> 4;
    end else begin
      dp_d      = dp_q;
      lzs_d     = lzs_q;
      on_time_d = on_time_q;
    end
  end

  // Output pattern for the current slot: glyph, dp, zero suppression and blanking.
  always_comb begin
    nib_s        = data_q[4*int'(idx_q) +: 4];
    upper_zero_s = 1'b1;
    for (int i = 0; i < DIGITS; i++) begin
      if ((i >= int'(idx_q)) && (data_q[4*i +: 4] != 4'd0)) begin
        upper_zero_s = 1'b0;
      end else begin
        upper_zero_s = upper_zero_s;
      end
    end
    blank_s = ({{(36-CW){1'b0}}, cnt_q} >= on_time_q) || blink_blank_s;
    if (blank_s) begin
      sel_d = '0;
      seg_d = 8'hFF;
    end else begin
      sel_d = {{(DIGITS-1){1'b0}}, 1'b1} << idx_q;
      if (lzs_q && (idx_q != '0) && upper_zero_s) begin
        seg_d = {~dp_q[idx_q], 7'h7F};
      end else begin
        seg_d = {~dp_q[idx_q], hex_glyph(nib_s)};
      end
    end
  end

  // Scan, data, config and output registers.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      cnt_q     <= '0;
      idx_q     <= '0;
      data_q    <= '0;
      dp_q      <= '0;
      lzs_q     <= 1'b0;
      on_time_q <= ON_RESET;
      sel_q     <= '0;
      seg_q     <= 8'hFF;
    end else begin
      cnt_q     <= cnt_d;
      idx_q     <= idx_d;
      data_q    <= data_d;
      dp_q      <= dp_d;
      lzs_q     <= lzs_d;
      on_time_q <= on_time_d;
      sel_q     <= sel_d;
      seg_q     <= seg_d;
    end
  end

  assign bus.sel = sel_q;
  assign bus.seg = seg_q;
endmodule

// File: tb/tb_digital_tube_scan.sv
// Directed bench for digital_tube_scan (DIGITS=8, SCAN_PERIOD=16, BLINK_FRAMES=2).
// A reference model predicts {sel,seg} for every output cycle; predictions are
// queued as stimulus is applied and compared once the DUT output is sampled.
module tb_digital_tube_scan;
  localparam int DG = 8;
  localparam int SP = 16;
  localparam int BF = 2;

  typedef struct {
    string       tag;
    logic [15:0] exp;
  } exp_t;

  logic clk;
  logic rstn;
  digital_tube_scan_if #(.DIGITS(DG)) bus ();

  digital_tube_scan #(.DIGITS(DG), .SCAN_PERIOD(SP), .BLINK_FRAMES(BF)) dut (
    .clk  (clk),
    .rstn (rstn),
    .bus  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  exp_t        sb[$];
  int          n_assert = 0;
  int          n_fail   = 0;
  int          n        = 0;
  logic [31:0] ref_data;
  logic [7:0]  ref_dp;
  logic [7:0]  ref_blink;
  logic        ref_lzs;
  int          ref_on;
  logic [7:0]  glyph_tab [16] = '{8'h81, 8'hCF, 8'h92, 8'h86, 8'hCC, 8'hA4, 8'hA0, 8'h8F,
                                  8'h80, 8'h84, 8'h88, 8'hE0, 8'hB1, 8'hC2, 8'hB0, 8'hB8};

  // Expected {sel,seg} visible after output edge m (m>=1) following reset release.
  function automatic logic [15:0] model(input int m);
    int         pos, cnt, idx, frame;
    logic [7:0] s;
    logic [3:0] nib;
    logic [31:0] upper;
    logic       blank;
    pos   = m - 1;
    cnt   = pos % SP;
    idx   = (pos / SP) % DG;
    frame = pos / (SP * DG);
    nib   = ref_data[4*idx +: 4];
    s     = glyph_tab[nib];
    upper = ref_data >> (4 * idx);
    if (ref_lzs && idx > 0 && upper == 32'd0) s = 8'hFF;
    if (ref_dp[idx]) s[7] = 1'b0;
    blank = (cnt >= ref_on);
`ifdef TUBE_BLINK_EN
    if (((frame / BF) % 2 == 1) && ref_blink[idx]) blank = 1'b1;
`endif
    if (blank) return {8'h00, 8'hFF};
    return {8'(1 << idx), s};
  endfunction

  task automatic pop_compare();
    exp_t        e;
    logic [15:0] got;
    e   = sb.pop_front();
    got = {bus.sel, bus.seg};
    n_assert++;
    assert (got === e.exp) else begin
      n_fail++;
      $error("FAIL %s: {sel,seg} observed %h expected %h (cycle %0d)", e.tag, got, e.exp, n);
    end
  endtask

  task automatic step_check(input string tag);
    sb.push_back('{tag, model(n + 1)});
    @(negedge clk);
    n++;
    pop_compare();
  endtask

  task automatic run_cycles(input string tag, input int cycles);
    for (int i = 0; i < cycles; i++) step_check(tag);
  endtask

  task automatic model_reset();
    ref_data  = 32'h0;
    ref_dp    = 8'h00;
    ref_blink = 8'h00;
    ref_lzs   = 1'b0;
    ref_on    = SP;
  endtask

  // One strobe cycle; the model changes only after the edge that latches it.
  task automatic drive(input string tag, input logic we, input logic [3:0] be,
                       input logic [31:0] wd, input logic cwe, input logic [7:0] dp,
                       input logic [7:0] blink, input logic lzs, input logic [3:0] bright);
    bus.wr_en      = we;
    bus.wr_be      = be;
    bus.wr_data    = wd;
    bus.cfg_we     = cwe;
    bus.cfg_dp     = dp;
    bus.cfg_blink  = blink;
    bus.cfg_lzs    = lzs;
    bus.cfg_bright = bright;
    step_check(tag);
    bus.wr_en  = 1'b0;
    bus.cfg_we = 1'b0;
    if (we) begin
      for (int k = 0; k < 4; k++) if (be[k]) ref_data[8*k +: 8] = wd[8*k +: 8];
    end
    if (cwe) begin
      ref_dp    = dp;
      ref_blink = blink;
      ref_lzs   = lzs;
      ref_on    = ((int'(bright) + 1) * SP) >> 4;
    end
  endtask

  initial begin
    logic        found;
    logic [15:0] cur;
    rstn = 1'b0;
    bus.wr_en = 1'b0; bus.wr_be = 4'h0; bus.wr_data = 32'h0;
    bus.cfg_we = 1'b0; bus.cfg_dp = 8'h00; bus.cfg_blink = 8'h00;
    bus.cfg_lzs = 1'b0; bus.cfg_bright = 4'd0;
    model_reset();
    repeat (3) @(negedge clk);
    sb.push_back('{"reset_state", {8'h00, 8'hFF}});
    pop_compare();
    rstn = 1'b1;
    n    = 0;

    // Full frame plus one: sel 01 -> 02 after 16 cycles, back to 01 after 128.
    run_cycles("idle_scan", SP * DG + 1);

    // Byte-lane write: only lanes 0 and 2 change.
    drive("be_write", 1'b1, 4'b0101, 32'h1234ABCD, 1'b0, 8'h00, 8'h00, 1'b0, 4'd15);
    run_cycles("be_frame", SP * DG);

    // Leading-zero suppression with dp on digit 2; data and config in one cycle.
    drive("lzs_write", 1'b1, 4'hF, 32'h0000_0050, 1'b1, 8'h04, 8'h00, 1'b1, 4'd15);
    run_cycles("lzs_frame", SP * DG);

    // Brightness 3: four active cycles then twelve blank per slot.
    drive("pwm_cfg", 1'b0, 4'h0, 32'h0, 1'b1, 8'h00, 8'h00, 1'b0, 4'd3);
    run_cycles("pwm_frame", SP * DG);

    // Blink digit 0 at full brightness over six frames.
    drive("blink_cfg", 1'b0, 4'h0, 32'h0, 1'b1, 8'h00, 8'h01, 1'b0, 4'd15);
    run_cycles("blink_frames", SP * DG * 6);

    // Non-trivial state, then seek digit 4 mid-slot for the reset check.
    drive("pre_reset", 1'b1, 4'hF, 32'h89ABCDEF, 1'b1, 8'hA5, 8'h00, 1'b1, 4'd7);
    found = 1'b0;
    for (int i = 0; i < 4 * SP * DG && !found; i++) begin
      step_check("seek");
      cur = model(n);
      if (cur[15:8] == 8'h10 && ((n - 1) % SP) == 5) found = 1'b1;
    end
    n_assert++;
    assert (found) else begin
      n_fail++;
      $error("FAIL seek_timeout: found observed %b expected 1", found);
    end

    // Asynchronous reset mid-slot clears outputs before any clock edge.
    rstn = 1'b0;
    #1;
    sb.push_back('{"async_reset", {8'h00, 8'hFF}});
    pop_compare();
    @(negedge clk);
    rstn = 1'b1;
    n    = 0;
    model_reset();
    run_cycles("post_reset", SP * DG);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
